// File: rtl/asg_keystream_ctrl.sv
// rtl/asg_keystream_ctrl.sv - seed loader, warm-up sequencer and byte packer for the alternating-step generator
module asg_keystream_ctrl #(
    parameter int R1_LEN = 19,
    parameter int R2_LEN = 22,
    parameter int R3_LEN = 23,
    parameter int WARMUP = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] num_bytes,
    input  logic        abort,
    input  logic        seed_valid,
    input  logic        seed_bit,
    output logic        seed_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [1:0]  asg_load_it,
    output logic        asg_load,
    output logic        asg_enable,
    input  logic        asg_new_bit
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] R1_LAST   = CNT_W'(R1_LEN - 1);
    localparam logic [CNT_W-1:0] R2_LAST   = CNT_W'(R2_LEN - 1);
    localparam logic [CNT_W-1:0] R3_LAST   = CNT_W'(R3_LEN - 1);
    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD1 = 3'd1,
        S_LOAD2 = 3'd2,
        S_LOAD3 = 3'd3,
        S_WARM  = 3'd4,
        S_RUN   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shift_q, shift_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       byte_cnt_q, byte_cnt_d;
    logic [15:0]       gen_cnt_q, gen_cnt_d;
    logic [15:0]       num_q, num_d;
    logic              done_q, done_d;

    logic              load_last;
    logic              warm_last;
    logic              accept;
    logic              last_accept;
    logic              gen_full;
    logic              stall;
    logic              step;

    // The load counter is shared by all three LOAD states and the warm-up phase.
    always_comb begin
        load_last = 1'b0;
        case (state_q)
            S_LOAD1: load_last = (cnt_q == R1_LAST);
            S_LOAD2: load_last = (cnt_q == R2_LAST);
            S_LOAD3: load_last = (cnt_q == R3_LAST);
            default: load_last = 1'b0;
        endcase
    end

    assign warm_last   = (cnt_q == WARM_LAST);
    assign accept      = out_valid_q & out_ready;
    assign last_accept = accept && (num_q != 16'd0) && ((byte_cnt_q + 16'd1) == num_q);
    assign gen_full    = (num_q != 16'd0) && (gen_cnt_q == num_q);
    // A completed byte cannot be written while the previous one is still waiting.
    assign stall       = (bit_cnt_q == 3'd7) && out_valid_q && !out_ready;
    assign step        = (state_q == S_RUN) && !stall && !gen_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_LOAD1;
                S_LOAD1: if (seed_valid && load_last) state_d = S_LOAD2;
                S_LOAD2: if (seed_valid && load_last) state_d = S_LOAD3;
                S_LOAD3: if (seed_valid && load_last) state_d = (WARMUP == 0) ? S_RUN : S_WARM;
                S_WARM:  if (warm_last) state_d = S_RUN;
                S_RUN:   if (last_accept) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        seed_ready  = 1'b0;
        asg_load_it = 2'b00;
        asg_load    = 1'b0;
        asg_enable  = 1'b0;
        busy        = (state_q != S_IDLE);
        case (state_q)
            S_LOAD1: begin
                seed_ready  = 1'b1;
                asg_load_it = seed_valid ? 2'b01 : 2'b00;
                asg_load    = seed_bit;
            end
            S_LOAD2: begin
                seed_ready  = 1'b1;
                asg_load_it = seed_valid ? 2'b10 : 2'b00;
                asg_load    = seed_bit;
            end
            S_LOAD3: begin
                seed_ready  = 1'b1;
                asg_load_it = seed_valid ? 2'b11 : 2'b00;
                asg_load    = seed_bit;
            end
            S_WARM:  asg_enable = 1'b1;
            S_RUN:   asg_enable = step;
            default: asg_enable = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            byte_cnt_q  <= '0;
            gen_cnt_q   <= '0;
            num_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            byte_cnt_q  <= byte_cnt_d;
            gen_cnt_q   <= gen_cnt_d;
            num_q       <= num_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        byte_cnt_d  = byte_cnt_q;
        gen_cnt_d   = gen_cnt_q;
        num_d       = num_q;
        done_d      = 1'b0;
        if (abort) begin
            cnt_d       = '0;
            bit_cnt_d   = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_d      = num_bytes;
                        cnt_d      = '0;
                        bit_cnt_d  = '0;
                        shift_d    = '0;
                        byte_cnt_d = '0;
                        gen_cnt_d  = '0;
                    end
                end
                S_LOAD1, S_LOAD2, S_LOAD3: begin
                    if (seed_valid) cnt_d = load_last ? '0 : cnt_q + 1'b1;
                end
                S_WARM: begin
                    cnt_d = warm_last ? '0 : cnt_q + 1'b1;
                end
                S_RUN: begin
                    if (accept) begin
                        out_valid_d = 1'b0;
                        byte_cnt_d  = byte_cnt_q + 16'd1;
                        done_d      = last_accept;
                    end
                    // A new byte may land in the same cycle the old one is taken.
                    if (step) begin
                        if (bit_cnt_q == 3'd7) begin
                            out_data_d  = {asg_new_bit, shift_q};
                            out_valid_d = 1'b1;
                            gen_cnt_d   = gen_cnt_q + 16'd1;
                        end else begin
                            shift_d[bit_cnt_q] = asg_new_bit;
                        end
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_asg_keystream_ctrl.sv
// tb/tb_asg_keystream_ctrl.sv - randomized checks of asg_keystream_ctrl against a bit-stream reference model
`timescale 1ns/1ps
module tb_asg_keystream_ctrl;

    localparam int MASK = 1023;

    int lens [2][3] = '{'{19, 22, 23}, '{4, 4, 4}};
    int warm [2]    = '{64, 0};

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        start_s [2];
    logic [15:0] nb [2];
    logic        abort_s [2];
    logic        sv [2];
    logic        sb [2];
    logic        sr [2];
    logic        ov [2];
    logic [7:0]  od [2];
    logic        ordy [2];
    logic        busy_s [2];
    logic        done_s [2];
    logic [1:0]  lit [2];
    logic        ld [2];
    logic        en [2];
    logic        nbit [2];

    bit gb [2][1024];
    int gidx0 = 0;
    int gidx1 = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    asg_keystream_ctrl u_dut0 (
        .clk(clk), .reset(rst_n[0]), .start(start_s[0]), .num_bytes(nb[0]), .abort(abort_s[0]),
        .seed_valid(sv[0]), .seed_bit(sb[0]), .seed_ready(sr[0]), .out_valid(ov[0]), .out_data(od[0]),
        .out_ready(ordy[0]), .busy(busy_s[0]), .done(done_s[0]), .asg_load_it(lit[0]), .asg_load(ld[0]),
        .asg_enable(en[0]), .asg_new_bit(nbit[0])
    );

    asg_keystream_ctrl #(.R1_LEN(4), .R2_LEN(4), .R3_LEN(4), .WARMUP(0)) u_dut1 (
        .clk(clk), .reset(rst_n[1]), .start(start_s[1]), .num_bytes(nb[1]), .abort(abort_s[1]),
        .seed_valid(sv[1]), .seed_bit(sb[1]), .seed_ready(sr[1]), .out_valid(ov[1]), .out_data(od[1]),
        .out_ready(ordy[1]), .busy(busy_s[1]), .done(done_s[1]), .asg_load_it(lit[1]), .asg_load(ld[1]),
        .asg_enable(en[1]), .asg_new_bit(nbit[1])
    );

    // Generator model: each enabled step advances to the next bit of a fixed random stream.
    always @(posedge clk) if (en[0]) gidx0 <= gidx0 + 1;
    always @(posedge clk) if (en[1]) gidx1 <= gidx1 + 1;
    assign nbit[0] = gb[0][gidx0 & MASK];
    assign nbit[1] = gb[1][gidx1 & MASK];

    function automatic int gi(input int d);
        return (d != 0) ? gidx1 : gidx0;
    endfunction

    function automatic logic [7:0] exp_byte(input int d, input int base, input int k);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = gb[d][(base + warm[d] + 8 * k + j) & MASK];
        return b;
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input int d);
        check_eq("rst_out_valid", ov[d], 0);
        check_eq("rst_out_data", od[d], 0);
        check_eq("rst_seed_ready", sr[d], 0);
        check_eq("rst_busy", busy_s[d], 0);
        check_eq("rst_done", done_s[d], 0);
        check_eq("rst_load_it", lit[d], 0);
        check_eq("rst_load", ld[d], 0);
        check_eq("rst_enable", en[d], 0);
    endtask

    task automatic begin_session(input int d, input int n, output int base);
        base = gi(d);
        nb[d] = 16'(n);
        start_s[d] = 1'b1;
        #1;
        check_eq("busy_before_start", busy_s[d], 0);
        @(negedge clk);
        start_s[d] = 1'b0;
        #1;
        check_eq("busy_after_start", busy_s[d], 1);
    endtask

    task automatic load_seed(input int d, input bit gaps, input bit fixed);
        int acc;
        int cyc;
        int reg_n;
        int total;
        int n_r [3];
        bit v;
        logic [11:0] fx;
        fx = 12'b1010_1100_1111;
        acc = 0;
        cyc = 0;
        n_r = '{0, 0, 0};
        total = lens[d][0] + lens[d][1] + lens[d][2];
        while (acc < total && cyc < 500) begin
            reg_n = (acc < lens[d][0]) ? 1 : (acc < lens[d][0] + lens[d][1]) ? 2 : 3;
            v = !(gaps && reg_n == 1 && (cyc % 2) == 1);
            sv[d] = v;
            sb[d] = (fixed && total == 12) ? fx[11 - acc] : 1'($urandom);
            #1;
            check_eq("seed_ready", sr[d], 1);
            check_eq("load_it", lit[d], v ? reg_n : 0);
            if (v) check_eq("load_bit", ld[d], sb[d]);
            check_eq("load_enable", en[d], 0);
            if (lit[d] != 2'b00) n_r[lit[d] - 1]++;
            if (v) acc++;
            cyc++;
            @(negedge clk);
        end
        sv[d] = 1'b0;
        check_eq("load_timeout", acc, total);
        for (int r = 0; r < 3; r++) check_eq("load_count", n_r[r], lens[d][r]);
    endtask

    // mode 0: always ready, 1: random ready, 2: ready held low 20 cycles after the first byte
    task automatic collect(input int d, input int n, input int base, input int mode);
        int k;
        int cyc;
        int hold;
        int last_acc;
        int s;
        bit seen_ov;
        bit prev_stall;
        bit acc;
        bit exp_en;
        logic [7:0] prev;
        k = 0; cyc = 0; hold = 20; last_acc = 0; seen_ov = 0; prev_stall = 0; prev = '0;
        while (k < n && cyc < 3000) begin
            case (mode)
                0: ordy[d] = 1'b1;
                1: ordy[d] = 1'($urandom);
                default: begin
                    if (ov[d] && hold > 0) begin
                        ordy[d] = 1'b0;
                        hold--;
                    end else begin
                        ordy[d] = 1'b1;
                    end
                end
            endcase
            #1;
            s = gi(d) - base - warm[d];
            if (!seen_ov && ov[d]) begin
                seen_ov = 1;
                check_eq("first_byte_latency", cyc, warm[d] + 8);
            end
            if (prev_stall) check_eq("held_data", od[d], prev);
            exp_en = (s < 0) ? 1'b1 : !((s >= 8 * n) || ((s % 8) == 7 && ov[d] && !ordy[d]));
            check_eq("step_enable", en[d], exp_en);
            check_eq("done_early", done_s[d], 0);
            acc = ov[d] && ordy[d];
            if (acc) begin
                check_eq("byte", od[d], exp_byte(d, base, k));
                if (mode == 0 && k > 0) check_eq("byte_interval", cyc - last_acc, 8);
                last_acc = cyc;
                k++;
            end
            prev_stall = ov[d] && !ordy[d];
            prev = od[d];
            cyc++;
            @(negedge clk);
        end
        ordy[d] = 1'b0;
        check_eq("bytes_received", k, n);
        #1;
        check_eq("done_pulse", done_s[d], 1);
        check_eq("busy_fall", busy_s[d], 0);
        @(negedge clk);
        #1;
        check_eq("done_single", done_s[d], 0);
    endtask

    initial begin
        int base;
        int cyc;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; start_s[d] = 1'b0; nb[d] = '0; abort_s[d] = 1'b0;
            sv[d] = 1'b0; sb[d] = 1'b0; ordy[d] = 1'b0;
            for (int i = 0; i < 1024; i++) gb[d][i] = 1'($urandom);
        end
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs(0);
        check_reset_outputs(1);
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);

        // Fixed seed through a short-register instance with no warm-up.
        begin_session(1, 2, base);
        load_seed(1, 0, 1);
        collect(1, 2, base, 0);

        // Single-bit pattern with seed gaps in LOAD1.
        begin_session(1, 3, base);
        for (int i = 0; i < 32; i++) gb[1][(base + i) & MASK] = (i % 8 == 0);
        load_seed(1, 1, 0);
        collect(1, 3, base, 0);

        // Full-length registers, 64-step warm-up and a long backpressure hold.
        begin_session(0, 4, base);
        load_seed(0, 0, 0);
        collect(0, 4, base, 2);

        // Abort three bits into the second byte of an unbounded session.
        begin_session(0, 0, base);
        load_seed(0, 0, 0);
        cyc = 0;
        while (gi(0) - base - warm[0] != 11 && cyc < 500) begin
            ordy[0] = 1'b1;
            cyc++;
            @(negedge clk);
        end
        check_eq("abort_reach_timeout", gi(0) - base - warm[0], 11);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        ordy[0] = 1'b0;
        #1;
        check_eq("abort_busy", busy_s[0], 0);
        check_eq("abort_out_valid", ov[0], 0);
        check_eq("abort_done", done_s[0], 0);
        check_eq("abort_enable", en[0], 0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check_eq("abort_no_done", done_s[0], 0);
        end
        begin_session(0, 2, base);
        load_seed(0, 0, 0);
        collect(0, 2, base, 1);

        // Asynchronous reset while loading R2.
        begin_session(0, 3, base);
        for (int i = 0; i < lens[0][0] + 5; i++) begin
            sv[0] = 1'b1;
            sb[0] = 1'b1;
            @(negedge clk);
        end
        rst_n[0] = 1'b0;
        #1;
        check_reset_outputs(0);
        sv[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk);
        begin_session(0, 2, base);
        load_seed(0, 0, 0);
        collect(0, 2, base, 1);

        // Randomized sessions on both instances.
        for (int it = 0; it < 6; it++) begin
            int d;
            int n;
            d = $urandom_range(1, 0);
            n = $urandom_range(5, 1);
            begin_session(d, n, base);
            load_seed(d, 1'($urandom), 0);
            collect(d, n, base, $urandom_range(1, 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/asg_keystream_ctrl.md
Name: asg_keystream_ctrl

Overview:
Sequencer for the alternating-step keystream generator (three LFSRs R1/R2/R3, 2-bit register-select load code, serial load bit, step enable, one output bit).
- Accepts a serial seed stream and loads R1, R2 and R3 in that order.
- Runs a discard warm-up, then packs generator bits into bytes on a valid/ready output stream.
- Sits between the CMAC datapath (seed source and keystream consumer) and the generator instance.

Parameters:
R1_LEN, 19, number of load cycles for R1 (its register length)
R2_LEN, 22, number of load cycles for R2
R3_LEN, 23, number of load cycles for R3
WARMUP, 64, generator steps whose output is discarded after loading; 0 allowed

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-low reset (0 = reset)
start  input  1  one-cycle request to begin a session; honoured only in IDLE
num_bytes  input  16  bytes to produce, sampled with start; 0 = run until abort
abort  input  1  return to IDLE next edge from any state
seed_valid  input  1  seed bit present
seed_bit  input  1  seed bit value
seed_ready  output  1  seed bit consumed this cycle
out_valid  output  1  out_data holds a keystream byte
out_data  output  8  keystream byte, first generated bit in bit 0
out_ready  input  1  consumer accepts byte
busy  output  1  state != IDLE
done  output  1  one-cycle pulse when the last requested byte is accepted
asg_load_it  output  2  generator register-select code: 00 none, 01 R1, 10 R2, 11 R3
asg_load  output  1  serial load bit to generator
asg_enable  output  1  generator step enable
asg_new_bit  input  1  generator output bit

Behaviour:
- Reset values: state IDLE; all counters 0; out_valid 0; out_data 0x00; seed_ready 0; busy 0; done 0; asg_load_it 00; asg_load 0; asg_enable 0.
- States: IDLE -> LOAD1 -> LOAD2 -> LOAD3 -> WARM -> RUN -> IDLE.
- IDLE:
  - start=1 latches num_bytes, clears the bit and byte counters, and goes to LOAD1.
  - start is ignored in every other state.
- LOADn (n = 1, 2, 3):
  - Outputs are combinational from state and seed_valid.
  - seed_ready = 1 in LOADn.
  - asg_load_it = n when seed_valid=1, else 00.
  - asg_load = seed_bit; asg_enable = 0 (the generator forces stepping of the selected register).
  - Each accepted bit (seed_valid & seed_ready) increments the load counter.
  - After Rn_LEN accepted bits, go to the next state. The counter clears on each transition.
  - No seed_valid means hold with no step.
- WARM:
  - asg_enable = 1 for exactly WARMUP cycles; asg_new_bit is ignored.
  - Then go to RUN. If WARMUP=0, LOAD3 goes directly to RUN.
- RUN:
  - In a step cycle (asg_enable=1), asg_new_bit is sampled into shift position bit_cnt (LSB first), then bit_cnt increments.
  - asg_enable = 1 except in the stall case: bit_cnt==7 and out_valid==1 and out_ready==0. In the stall case, asg_enable=0 and no bit is sampled.
  - A step with bit_cnt==7 loads the completed byte into out_data, sets out_valid, and wraps bit_cnt to 0. This is allowed in the same cycle an old byte is accepted.
  - out_valid stays high and out_data stays stable until out_ready=1.
  - The byte counter increments on each accepted byte.
- Completion (num_bytes != 0):
  - Stepping stops once num_bytes bytes have been generated.
  - done pulses in the cycle after the acceptance of byte num_bytes, and state returns to IDLE on that same edge.
  - num_bytes=0: RUN continues until abort.
- abort:
  - Next edge: state IDLE, out_valid 0, bit_cnt 0.
  - Any partial byte is discarded and done is not pulsed.
  - Generator contents are not cleared; a new start reloads them.
  - abort takes priority over start in the same cycle.
- Reset mid-operation forces all reset values immediately; no cleanup handshake.
- Throughput in RUN: 1 byte per 8 cycles with out_ready held 1.
- Latency from the final seed bit accepted to the first out_valid: WARMUP + 8 cycles.

Test Plan:
- Load sequence with R1_LEN=R2_LEN=R3_LEN=4, WARMUP=0; feed seed 1010 1100 1111 continuously -> asg_load_it = 01 x4, 10 x4, 11 x4; asg_load matches the seed; asg_enable=0 throughout; then RUN.
- Seed gaps: seed_valid toggling 1,0,1,0 in LOAD1 -> asg_load_it=00 on gap cycles; the load counter advances only on valid cycles; exactly R1_LEN loads of R1.
- Packing with a generator model producing bit pattern 1,0,0,0,0,0,0,0 repeated, num_bytes=3, out_ready=1 -> three bytes 0x01, 8 cycles apart; done one pulse; busy falls.
- Backpressure with out_ready=0 for 20 cycles after the first byte -> out_data stable; asg_enable drops at bit_cnt==7; no bits lost; compare the full stream to a reference model.
- Warm-up with WARMUP=64 -> exactly 64 enabled cycles between LOAD3 exit and the first sampled bit; the first byte equals model bits 64..71.
- Abort and reset: abort mid-RUN with bit_cnt=3 -> IDLE next edge, out_valid=0, no done; then start works. Reset pulse mid-LOAD2 -> all outputs at reset values asynchronously.
